mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 2, max consecutive data-port grants while fetch waits.
REQ-002 Parameter LOAD_BASE, 32'h8002_0000, lowest address the loader may write; loader writes below it are dropped.
REQ-003 clock  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 load_done  in  1  S-record loader finished.
REQ-006 ld_req / ld_wren  in  1 each  loader request / write enable.
REQ-007 ld_address, ld_data_in  in  [0:31] each  loader address / write data.
REQ-008 if_req  in  1  fetch read request.
REQ-009 if_address  in  [0:31]  fetch address.
REQ-010 dm_req / dm_wren  in  1 each  data-port request / write enable.
REQ-011 dm_address, dm_data_in  in  [0:31] each  data-port address / write data.
REQ-012 ld_gnt, if_gnt, dm_gnt  out  1 each  one-hot grant, same cycle as request.
REQ-013 if_stall  out  1  if_req high and if_gnt low.
REQ-014 if_rvalid, dm_rvalid  out  1 each  read data valid for that port.
REQ-015 rdata  out  [0:31]  read data, equal to mem_data_out.
REQ-016 mem_address, mem_data_in  out  [0:31] each  to mem_controller.
REQ-017 mem_wren  out  1  to mem_controller.
REQ-018 mem_data_out  in  [0:31]  from mem_controller, valid one cycle after read address.

Function
REQ-019 State machine SHALL have states LOAD and RUN; reset enters LOAD.
REQ-020 LOAD -> RUN on a posedge with load_done=1; RUN has no exit except reset.
REQ-021 In LOAD, only ld_req is grantable; if_gnt=dm_gnt=0 and if_stall follows if_req.
REQ-022 In RUN, ld_req is ignored; ld_gnt=0.
REQ-023 In RUN, dm_req SHALL beat if_req, unless streak==STARVE_LIMIT and if_req=1, in which case fetch wins.
REQ-024 streak counter: +1 on a dm grant with if_req=1; cleared on an if grant or any cycle with if_req=0; saturates at STARVE_LIMIT.
REQ-025 mem_address/mem_wren/mem_data_in SHALL mux combinationally from the granted port; with no grant, mem_wren=0 and mem_address holds its last granted value.
REQ-026 Fetch is read-only: if grant forces mem_wren=0.
REQ-027 Loader write with ld_address < LOAD_BASE: ld_gnt=1, mem_wren=0.
REQ-028 Read latency exactly 1: a read grant in cycle N raises that port's rvalid in cycle N+1 for one cycle; writes raise no rvalid.
REQ-029 Back-to-back reads from alternating ports SHALL return in grant order, one per cycle.
REQ-030 load_done and ld_req in the same cycle: loader request is served, then RUN next cycle.

Reset
REQ-031 On reset: state=LOAD, streak=0, rvalid pipeline cleared, mem_address=0, all grants and rvalids 0 in the following cycle.
REQ-032 Reset mid-operation drops any in-flight rvalid; no rvalid SHALL appear the cycle after reset.

Structure
REQ-033 State encoding (ARB_LOAD, ARB_RUN) and LOAD_BASE default SHALL live in the shared processor constants package.
REQ-034 Grant selection SHALL be one sub-module, arb_prio, pure combinational (reqs, streak, state -> one-hot grant); the rest is the top level.

Verification
REQ-035 Reset, ld_req with ld_address=8002_0000, wren=1, data=DEADBEEF -> ld_gnt=1, mem_wren=1, mem_data_in=DEADBEEF same cycle.
REQ-036 In LOAD, if_req=1 for 5 cycles -> if_gnt=0, if_stall=1 throughout; load_done=1 -> if_gnt=1 next cycle.
REQ-037 RUN, dm_req and if_req held high, STARVE_LIMIT=2 -> grant pattern dm,dm,if,dm,dm,if.
REQ-038 RUN, if read of 8002_0004 in cycle N -> if_rvalid=1 only in N+1, rdata equals stored word.
REQ-039 Read granted then reset in same cycle -> no rvalid next cycle; state=LOAD.
REQ-040 Loader write to 0000_1000 -> ld_gnt=1, mem_wren=0; readback unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared processor constants for the memory arbiter: state encoding, default
// loader window base, and the grant and streak types used by the arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_LOAD = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_e;

    localparam logic [31:0] LOAD_BASE_DEFAULT    = 32'h8002_0000;
    localparam int          STARVE_LIMIT_DEFAULT = 2;

    // Limits STARVE_LIMIT to 255.
    typedef logic [7:0] streak_t;

    typedef struct packed {
        logic ld;
        logic fetch;
        logic dm;
    } arb_gnt_t;

    function automatic streak_t sat_inc(input streak_t value, input streak_t limit);
        if (value >= limit) begin
            return limit;
        end
        return value + streak_t'(1);
    endfunction

endpackage

// File: rtl/arb_prio.sv
// Combinational grant selection: loader only in LOAD, data port over fetch in
// RUN unless the data port has won STARVE_LIMIT times in a row while fetch waited.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  arb_state_e state_i,
    input  logic       ld_req_i,
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  streak_t    streak_i,
    output arb_gnt_t   gnt_o
);

    logic fetch_turn;

    assign fetch_turn = if_req_i && (streak_i == streak_t'(STARVE_LIMIT));

    always_comb begin
        gnt_o = '0;
        if (state_i == ARB_LOAD) begin
            gnt_o.ld = ld_req_i;
        end else if (dm_req_i && !fetch_turn) begin
            gnt_o.dm = 1'b1;
        end else if (if_req_i) begin
            gnt_o.fetch = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between the S-record loader, instruction fetch
// and the data port, with a one-cycle read-valid pipeline per reading port.
//
// state    | meaning
// ARB_LOAD | only the loader may access memory; fetch stalls
// ARB_RUN  | data port and fetch share memory; loader ignored
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter logic [31:0] LOAD_BASE    = LOAD_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_done,
    input  logic        ld_req,
    input  logic        ld_wren,
    input  logic [0:31] ld_address,
    input  logic [0:31] ld_data_in,
    input  logic        if_req,
    input  logic [0:31] if_address,
    input  logic        dm_req,
    input  logic        dm_wren,
    input  logic [0:31] dm_address,
    input  logic [0:31] dm_data_in,
    output logic        ld_gnt,
    output logic        if_gnt,
    output logic        dm_gnt,
    output logic        if_stall,
    output logic        if_rvalid,
    output logic        dm_rvalid,
    output logic [0:31] rdata,
    output logic [0:31] mem_address,
    output logic [0:31] mem_data_in,
    output logic        mem_wren,
    input  logic [0:31] mem_data_out
);

    arb_state_e  state_q, state_d;
    streak_t     streak_q, streak_d;
    logic [0:31] addr_q, addr_d;
    logic        if_rv_q, if_rv_d;
    logic        dm_rv_q, dm_rv_d;
    arb_gnt_t    gnt;
    logic        ld_write_ok;

    arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .state_i (state_q),
        .ld_req_i(ld_req),
        .if_req_i(if_req),
        .dm_req_i(dm_req),
        .streak_i(streak_q),
        .gnt_o   (gnt)
    );

    // Loader writes below the protected window are granted but never reach memory.
    assign ld_write_ok = ld_wren && (ld_address >= LOAD_BASE);

    always_comb begin
        addr_d      = addr_q;
        mem_wren    = 1'b0;
        mem_data_in = '0;
        if (gnt.ld) begin
            addr_d      = ld_address;
            mem_wren    = ld_write_ok;
            mem_data_in = ld_data_in;
        end else if (gnt.fetch) begin
            addr_d = if_address;
        end else if (gnt.dm) begin
            addr_d      = dm_address;
            mem_wren    = dm_wren;
            mem_data_in = dm_data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ARB_LOAD && load_done) begin
            state_d = ARB_RUN;
        end

        streak_d = streak_q;
        if (gnt.dm && if_req) begin
            streak_d = sat_inc(streak_q, streak_t'(STARVE_LIMIT));
        end else if (gnt.fetch || !if_req) begin
            streak_d = '0;
        end

        if_rv_d = gnt.fetch;
        dm_rv_d = gnt.dm && !dm_wren;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARB_LOAD;
            streak_q <= '0;
            addr_q   <= '0;
            if_rv_q  <= 1'b0;
            dm_rv_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            if_rv_q  <= if_rv_d;
            dm_rv_q  <= dm_rv_d;
        end
    end

    assign ld_gnt      = gnt.ld;
    assign if_gnt      = gnt.fetch;
    assign dm_gnt      = gnt.dm;
    assign if_stall    = if_req && !gnt.fetch;
    assign if_rvalid   = if_rv_q;
    assign dm_rvalid   = dm_rv_q;
    assign rdata       = mem_data_out;
    assign mem_address = addr_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and
// arbitration model; directed sequences precede the random phase.
module tb_mem_arbiter;

    localparam int          LIMIT = 2;
    localparam logic [31:0] BASE  = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset, load_done, ld_req, ld_wren, if_req, dm_req, dm_wren;
    logic [0:31] ld_address, ld_data_in, if_address, dm_address, dm_data_in;
    logic        ld_gnt, if_gnt, dm_gnt, if_stall, if_rvalid, dm_rvalid, mem_wren;
    logic [0:31] rdata, mem_address, mem_data_in, mem_data_out;

    always #5 clock = ~clock;

    mem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .LOAD_BASE   (BASE)
    ) dut (
        .clock(clock), .reset(reset), .load_done(load_done),
        .ld_req(ld_req), .ld_wren(ld_wren), .ld_address(ld_address), .ld_data_in(ld_data_in),
        .if_req(if_req), .if_address(if_address),
        .dm_req(dm_req), .dm_wren(dm_wren), .dm_address(dm_address), .dm_data_in(dm_data_in),
        .ld_gnt(ld_gnt), .if_gnt(if_gnt), .dm_gnt(dm_gnt), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .dm_rvalid(dm_rvalid), .rdata(rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_wren(mem_wren),
        .mem_data_out(mem_data_out)
    );

    // External memory: one-cycle read latency, addresses drawn from a small pool.
    logic [31:0] env_mem [16];

    function automatic int idx(input logic [31:0] a);
        return {a[17], a[4:2]};
    endfunction

    always @(posedge clock) begin
        mem_data_out <= env_mem[idx(mem_address)];
        if (mem_wren) env_mem[idx(mem_address)] <= mem_data_in;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        ld, fi, dm, wren, stall;
        logic [31:0] addr, data;
    } cyc_t;

    typedef struct {
        int          cyc;
        logic        is_if;
        logic [31:0] data;
    } rd_t;

    cyc_t cq[$];
    rd_t  rq[$];

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    int          m_st   = 0;   // 0 = loading, 1 = running
    int          m_wins = 0;   // data-port wins in a row while fetch waited
    logic [31:0] m_last = '0;
    logic [31:0] m_mem [logic [31:0]];

    function automatic logic [31:0] mread(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : 32'h0;
    endfunction

    task automatic step(input logic rst, input logic ldone,
                        input logic ldr, input logic ldw, input logic [31:0] lda, input logic [31:0] ldd,
                        input logic ifr, input logic [31:0] ifa,
                        input logic dmr, input logic dmw, input logic [31:0] dma, input logic [31:0] dmd);
        cyc_t e;
        @(posedge clock);
        #1;
        reset = rst; load_done = ldone;
        ld_req = ldr; ld_wren = ldw; ld_address = lda; ld_data_in = ldd;
        if_req = ifr; if_address = ifa;
        dm_req = dmr; dm_wren = dmw; dm_address = dma; dm_data_in = dmd;

        e.cyc = cyc;
        e.ld = 1'b0; e.fi = 1'b0; e.dm = 1'b0;
        if (m_st == 0) e.ld = ldr;
        else if (dmr && !(ifr && m_wins >= LIMIT)) e.dm = 1'b1;
        else if (ifr) e.fi = 1'b1;
        e.wren  = e.ld ? (ldw && lda >= BASE) : (e.dm ? dmw : 1'b0);
        e.addr  = e.ld ? lda : e.fi ? ifa : e.dm ? dma : m_last;
        e.data  = e.ld ? ldd : dmd;
        e.stall = ifr && !e.fi;
        cq.push_back(e);

        if (!rst && e.fi) rq.push_back('{cyc + 1, 1'b1, mread(ifa)});
        if (!rst && e.dm && !dmw) rq.push_back('{cyc + 1, 1'b0, mread(dma)});
        if (e.wren) m_mem[e.addr] = e.data;
        m_last = e.addr;

        if (rst) begin
            m_st = 0; m_wins = 0; m_last = '0;
        end else begin
            if (e.dm && ifr) m_wins = (m_wins + 1 > LIMIT) ? LIMIT : m_wins + 1;
            else if (e.fi || !ifr) m_wins = 0;
            if (m_st == 0 && ldone) m_st = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every driven cycle and every read return.
    always @(negedge clock) begin
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            cyc_t e;
            logic exp_if, exp_dm;
            e = cq.pop_front();
            chk("ld_gnt", 32'(ld_gnt), 32'(e.ld));
            chk("if_gnt", 32'(if_gnt), 32'(e.fi));
            chk("dm_gnt", 32'(dm_gnt), 32'(e.dm));
            chk("if_stall", 32'(if_stall), 32'(e.stall));
            chk("mem_wren", 32'(mem_wren), 32'(e.wren));
            chk("mem_address", mem_address, e.addr);
            if (e.wren) chk("mem_data_in", mem_data_in, e.data);

            exp_if = rq.size() > 0 && rq[0].cyc == cyc && rq[0].is_if;
            exp_dm = rq.size() > 0 && rq[0].cyc == cyc && !rq[0].is_if;
            chk("if_rvalid", 32'(if_rvalid), 32'(exp_if));
            chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm));
            if (exp_if || exp_dm) begin
                rd_t r;
                r = rq.pop_front();
                chk("rdata", rdata, r.data);
            end
        end
    end

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return BASE;
            1:       return BASE + 32'd4;
            2:       return BASE + 32'd8;
            3:       return BASE + 32'd12;
            4:       return BASE - 32'd4;
            default: return 32'h0000_1000;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) env_mem[i] = '0;
        reset = 1'b1; load_done = 0; ld_req = 0; ld_wren = 0; ld_address = 0; ld_data_in = 0;
        if_req = 0; if_address = 0; dm_req = 0; dm_wren = 0; dm_address = 0; dm_data_in = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Loader writes, including one below the protected window.
        step(0, 0, 1, 1, BASE, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, BASE + 4, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h0000_1000, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0);

        // Fetch stalls during LOAD; last loader write coincides with load_done.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, BASE, 0, 0, 0, 0);
        step(0, 1, 1, 1, BASE + 8, 32'h0BAD_F00D, 1, BASE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, BASE, 0, 0, 0, 0);

        // Starvation pattern with both ports held high.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, BASE, 1, 0, BASE + 8, 0);
        idle(1);

        // Single fetch read, readback of dropped write, ignored loader in RUN.
        step(0, 0, 0, 0, 0, 0, 1, BASE + 4, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 1, 1, BASE + 12, 32'h5555_AAAA, 0, 0, 1, 0, 32'h0000_1000, 0);
        idle(1);

        // Alternating back-to-back reads.
        step(0, 0, 0, 0, 0, 0, 1, BASE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BASE + 4, 0);
        step(0, 0, 0, 0, 0, 0, 1, BASE + 8, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BASE, 0);
        idle(1);

        // Read granted in the same cycle as reset, then confirm LOAD.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, BASE, 0);
        step(0, 0, 0, 0, 0, 0, 1, BASE, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, pick_addr(), $urandom(),
                 $urandom_range(0, 1) == 1, pick_addr(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, pick_addr(), $urandom());
        end
        idle(3);
        @(negedge clock);
        chk("reads_outstanding", 32'(rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
